// File: rtl/jk_reg_sequencer.sv
// Command-driven controller for a WIDTH-bit JK flip-flop bank (set/clear/toggle/load/count with repeat).
// Optional feature macro: JK_SEQ_COUNT_EN enables op 5 (COUNT) on the masked subfield.
module jk_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r, mask_r;
  logic [REP_W-1:0] rep_r, rep_cnt;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             accept, op_legal;

  always_comb begin
    op_legal = (cmd_op <= 3'd4);
`ifdef JK_SEQ_COUNT_EN
    if (cmd_op == 3'd5) op_legal = 1'b1;
`endif
  end

  assign accept = cmd_valid && (state == IDLE);

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = op_legal ? EXEC : DONE;
      end
      EXEC: begin
        busy = 1'b1;
        if (rep_cnt == rep_r) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef JK_SEQ_COUNT_EN
  // Ripple-carry toggle enables: a masked bit toggles when every lower masked bit is 1.
  logic [WIDTH-1:0] count_t;
  logic             carry;
  always_comb begin
    count_t = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask_r[i]) begin
        count_t[i] = carry;
        carry      = carry & q[i];
      end
    end
  end
`endif

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state == EXEC) begin
      case (op_r)
        3'd1: k_vec = mask_r;
        3'd2: j_vec = mask_r;
        3'd3: begin
          j_vec = mask_r;
          k_vec = mask_r;
        end
        3'd4: begin
          j_vec = data_r & mask_r;
          k_vec = ~data_r & mask_r;
        end
`ifdef JK_SEQ_COUNT_EN
        3'd5: begin
          j_vec = count_t;
          k_vec = count_t;
        end
`endif
        default: begin
          j_vec = '0;
          k_vec = '0;
        end
      endcase
    end
  end

  // JK characteristic: q+ = J&~q | ~K&q, applied to every bit each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= '0;
      data_r  <= '0;
      mask_r  <= '0;
      rep_r   <= '0;
      rep_cnt <= '0;
      err     <= 1'b0;
      q       <= '0;
    end else begin
      state <= state_next;
      q     <= (j_vec & ~q) | (~k_vec & q);
      if (accept) begin
        op_r    <= cmd_op;
        data_r  <= cmd_data;
        mask_r  <= cmd_mask;
        rep_r   <= cmd_rep;
        rep_cnt <= '0;
        err     <= ~op_legal;
      end else if (state == EXEC) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign qb = ~q;

endmodule
